// File: rtl/mc_ctrl_if.sv
// Control bundle between the tinymips multicycle controller and its datapath.
// The controller (master) consumes instr/zero/mem_rdy and drives every select and strobe.
interface mc_ctrl_if #(
    parameter int STATE_W  = 4,
    parameter int RETIRE_W = 32
);
    logic [31:0]         instr;
    logic                zero;
    logic                mem_rdy;
    logic                irwrite;
    logic                pcwrite;
    logic                iord;
    logic                memwrite;
    logic                regwrite;
    logic                regdst;
    logic                memtoreg;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [1:0]          pcsrc;
    logic [2:0]          aluctrl;
    logic                illegal;
    logic [STATE_W-1:0]  state;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  instr, zero, mem_rdy,
        output irwrite, pcwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluctrl, illegal, state, retired
    );

    modport slave (
        output instr, zero, mem_rdy,
        input  irwrite, pcwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluctrl, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for tinymips: decodes lw/sw/R/addi/beq/j and sequences
// the shared-memory datapath, one Moore state per clock, with a retired-instruction counter.
module mc_ctrl_fsm #(
    parameter int STATE_W  = 4,
    parameter int RETIRE_W = 32
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t                state_q, state_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic       irwrite, pcwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctrl;
    logic       retire;

    logic [5:0] opcode, funct;
    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // Memory handshake: a fetch/load/store access is issued for as long as the FSM
    // sits in FETCH/MEMRD/MEMWR and completes on the first cycle with mem_rdy=1;
    // strobes qualified by it (irwrite, pcwrite in FETCH) fire only in that cycle.
    always_comb begin
        state_d  = state_q;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluctrl  = 3'b000;
        illegal  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                aluctrl = 3'b010;
                if (bus.mem_rdy) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluctrl = 3'b010;
                case (opcode)
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h00:        state_d = S_EXEC;
                    6'h08:        state_d = S_ADDIEX;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluctrl = 3'b010;
                state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (bus.mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (bus.mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    6'd32:   aluctrl = 3'b010;
                    6'd34:   aluctrl = 3'b110;
                    6'd36:   aluctrl = 3'b000;
                    6'd37:   aluctrl = 3'b001;
                    6'd42:   aluctrl = 3'b111;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluctrl = 3'b010;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluctrl = 3'b110;
                pcsrc   = 2'b01;
                pcwrite = bus.zero;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are masked by reset so an aborted instruction cannot write anything.
    assign bus.irwrite  = irwrite  & rst_n_i;
    assign bus.pcwrite  = pcwrite  & rst_n_i;
    assign bus.memwrite = memwrite & rst_n_i;
    assign bus.regwrite = regwrite & rst_n_i;
    assign bus.illegal  = illegal  & rst_n_i;
    assign bus.iord     = iord;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.aluctrl  = aluctrl;
    assign bus.state    = STATE_W'(state_q);
    assign bus.retired  = retired_q;
endmodule
